// File: rtl/wave_rom_sequencer.sv
// Phase-accumulator waveform sequencer: walks an external synchronous ROM and
// streams samples to a DAC in bursts of whole waveform periods or until stopped.
module wave_rom_sequencer #(
    parameter int                    ADDR_WIDTH  = 10,
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    PHASE_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] IDLE_LEVEL  = 8'h80
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic [PHASE_WIDTH-1:0] ftw_in,
    input  logic                   ftw_load,
    input  logic [ADDR_WIDTH-1:0]  phase_off,
    input  logic [15:0]            periods,
    output logic [ADDR_WIDTH-1:0]  rom_addr,
    input  logic [DATA_WIDTH-1:0]  rom_data,
    output logic [DATA_WIDTH-1:0]  da_data,
    output logic                   da_valid,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                  state_r;
    logic [PHASE_WIDTH-1:0]  acc_r;
    logic [PHASE_WIDTH-1:0]  ftw_r;
    logic [15:0]             per_cnt_r;
    logic [15:0]             periods_r;
    logic                    drain_cnt_r;
    logic [ADDR_WIDTH-1:0]   addr_hold_r;
    logic                    addr_vld_d1_r;
    logic                    da_valid_r;
    logic [DATA_WIDTH-1:0]   da_data_r;
    logic                    done_r;

    logic [PHASE_WIDTH:0]    acc_sum_s;
    logic                    carry_s;
    logic [ADDR_WIDTH-1:0]   run_addr_s;
    logic [15:0]             per_cnt_next_s;
    logic                    burst_end_s;

    // Accumulator step, period counting and burst-termination decision.
    always_comb begin
        acc_sum_s  = {1'b0, acc_r} + {1'b0, ftw_r};
        carry_s    = acc_sum_s[PHASE_WIDTH];
        run_addr_s = acc_r[PHASE_WIDTH-1 -: ADDR_WIDTH] + phase_off;
        if (carry_s && (per_cnt_r != 16'hFFFF)) begin
            per_cnt_next_s = per_cnt_r + 16'd1;
        end else begin
            per_cnt_next_s = per_cnt_r;
        end
        burst_end_s = stop ||
                      ((periods_r != 16'd0) && carry_s && (per_cnt_next_s == periods_r));
    end

    // ROM address is live while running and frozen at the last issued value otherwise.
    always_comb begin
        if (state_r == RUN) begin
            rom_addr = run_addr_s;
        end else begin
            rom_addr = addr_hold_r;
        end
    end

    assign busy     = (state_r != IDLE);
    assign da_data  = da_data_r;
    assign da_valid = da_valid_r;
    assign done     = done_r;

    // Sequencer state, accumulator and the two-stage sample pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            acc_r         <= '0;
            ftw_r         <= '0;
            per_cnt_r     <= 16'd0;
            periods_r     <= 16'd0;
            drain_cnt_r   <= 1'b0;
            addr_hold_r   <= '0;
            addr_vld_d1_r <= 1'b0;
            da_valid_r    <= 1'b0;
            da_data_r     <= IDLE_LEVEL;
            done_r        <= 1'b0;
        end else begin
            if (ftw_load) begin
                ftw_r <= ftw_in;
            end
            done_r        <= 1'b0;
            addr_vld_d1_r <= (state_r == RUN);
            da_valid_r    <= addr_vld_d1_r;
            da_data_r     <= addr_vld_d1_r ? rom_data : IDLE_LEVEL;
            case (state_r)
                IDLE: begin
                    if (start && !stop) begin
                        state_r   <= RUN;
                        acc_r     <= '0;
                        per_cnt_r <= 16'd0;
                        periods_r <= periods;
                    end
                end
                RUN: begin
                    acc_r       <= acc_sum_s[PHASE_WIDTH-1:0];
                    per_cnt_r   <= per_cnt_next_s;
                    addr_hold_r <= run_addr_s;
                    if (burst_end_s) begin
                        state_r     <= DRAIN;
                        drain_cnt_r <= 1'b0;
                    end
                end
                DRAIN: begin
                    // done lands on the second drain cycle, alongside the final sample.
                    if (drain_cnt_r) begin
                        state_r <= IDLE;
                    end else begin
                        drain_cnt_r <= 1'b1;
                        done_r      <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wave_rom_sequencer.sv
// Scoreboard bench for wave_rom_sequencer: bursts are modelled as arithmetic
// phase sequences, expected samples are queued and a negedge monitor checks them.
module tb_wave_rom_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic [31:0] ftw_in;
    logic        ftw_load;
    logic [9:0]  phase_off;
    logic [15:0] periods;
    logic [9:0]  rom_addr;
    logic [7:0]  rom_data;
    logic [7:0]  da_data;
    logic        da_valid;
    logic        busy;
    logic        done;

    wave_rom_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .ftw_in    (ftw_in),
        .ftw_load  (ftw_load),
        .phase_off (phase_off),
        .periods   (periods),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .da_data   (da_data),
        .da_valid  (da_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        rom_mode = 1'b0;
    logic        mon_en = 1'b0;
    logic [7:0]  exp_q[$];
    int          done_cnt = 0;
    int          done_cyc = -1;
    int          first_valid_cyc = -1;
    int          stop_cyc = -1;
    logic [9:0]  addr_log [16];

    function automatic logic [7:0] rom_fn(input logic [9:0] a);
        logic [7:0] m;
        m = a[7:0] * 8'd37;
        if (rom_mode == 1'b0) return a[7:0];
        return m ^ {a[9:8], a[9:8], a[9:8], a[9:8]};
    endfunction

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rom_data <= rom_fn(rom_addr);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every presented sample is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (mon_en) begin
            if (da_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_sample: got %0d expected none", da_data);
                end else begin
                    chk("da_data", {56'd0, da_data}, {56'd0, exp_q.pop_front()});
                end
                if (done) chk("done_on_last", 64'(exp_q.size()), 64'd0);
            end else begin
                chk("idle_level", {56'd0, da_data}, 64'h80);
                if (done) chk("done_without_valid", {63'd0, done}, 64'd0);
            end
        end
    end

    // One burst; ftw2 is loaded in RUN cycle load_at and stop asserted in RUN cycle stop_at.
    task automatic run_burst(input logic [31:0] ftw, input logic [9:0] off, input logic [15:0] per,
                             input int stop_at, input int load_at, input logic [31:0] ftw2);
        logic [63:0] sum;
        logic [31:0] low;
        logic [9:0]  a;
        int          n;
        int          j;
        int          s;
        int          dc;
        sum = 64'd0;
        n   = 0;
        while (1) begin
            low = sum[31:0];
            a   = low[31:22] + off;
            exp_q.push_back(rom_fn(a));
            sum = sum + ((load_at >= 0 && n > load_at) ? {32'd0, ftw2} : {32'd0, ftw});
            if (n == stop_at) break;
            if (per != 16'd0 && sum[63:32] >= {16'd0, per}) break;
            n++;
            if (n > 20000) break;
        end
        @(posedge clk); #1;
        ftw_in = ftw; ftw_load = 1'b1;
        @(posedge clk); #1;
        ftw_load = 1'b0; phase_off = off; periods = per; start = 1'b1;
        s = cyc; dc = done_cnt; first_valid_cyc = -1; stop_cyc = -1;
        j = 0;
        while (1) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (!busy) break;
            if (j < 16) addr_log[j] = rom_addr;
            stop     = (j == stop_at);
            if (stop) stop_cyc = cyc;
            ftw_load = (j == load_at);
            ftw_in   = ftw2;
            j++;
            if (j > 20000) begin
                checks++; errors++;
                $display("FAIL burst_timeout: got busy after %0d cycles expected idle", j);
                break;
            end
        end
        stop = 1'b0; ftw_load = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("done_count", 64'(done_cnt - dc), 64'd1);
        chk("first_latency", 64'(first_valid_cyc), 64'(s + 3));
        exp_q.delete();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int dc;
        logic [31:0] f;
        rst = 1'b1; start = 1'b0; stop = 1'b0; ftw_in = 32'd0; ftw_load = 1'b0;
        phase_off = 10'd0; periods = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rom_addr", {54'd0, rom_addr}, 64'd0);
        chk("rst_da_data", {56'd0, da_data}, 64'h80);
        chk("rst_da_valid", {63'd0, da_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        mon_en = 1'b1;

        // One full period at unit step: 1024 samples 00..FF repeating.
        run_burst(32'h0040_0000, 10'd0, 16'd1, -1, -1, 32'h0040_0000);
        // Two periods at double step.
        run_burst(32'h0080_0000, 10'd0, 16'd2, -1, -1, 32'h0080_0000);
        // Continuous burst cut by stop at RUN cycle 100.
        run_burst(32'h0040_0000, 10'd0, 16'd0, 100, -1, 32'h0040_0000);
        chk("done_after_stop", 64'(done_cyc), 64'(stop_cyc + 2));
        // Address wrap through the offset.
        run_burst(32'h0040_0000, 10'd1023, 16'd0, 5, -1, 32'h0040_0000);
        chk("wrap_addr0", {54'd0, addr_log[0]}, 64'd1023);
        chk("wrap_addr1", {54'd0, addr_log[1]}, 64'd0);
        chk("wrap_addr2", {54'd0, addr_log[2]}, 64'd1);
        // Tuning word change mid-burst.
        run_burst(32'h0040_0000, 10'd0, 16'd0, 20, 10, 32'h0080_0000);
        chk("ftw_step_old", {54'd0, addr_log[11]}, 64'd11);
        chk("ftw_step_new", {54'd0, addr_log[12]}, 64'd13);

        // start together with stop in IDLE is refused.
        @(posedge clk); #1;
        start = 1'b1; stop = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
        chk("start_stop_busy", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
        chk("start_stop_busy2", {63'd0, busy}, 64'd0);

        // Reset in RUN cycle 50 aborts without done.
        mon_en = 1'b0;
        ftw_in = 32'h0040_0000; ftw_load = 1'b1; periods = 16'd0; phase_off = 10'd0; start = 1'b1;
        @(posedge clk); #1;
        ftw_load = 1'b0; start = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        chk("pre_rst_busy", {63'd0, busy}, 64'd1);
        dc = done_cnt;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_rom_addr", {54'd0, rom_addr}, 64'd0);
        chk("abort_da_data", {56'd0, da_data}, 64'h80);
        chk("abort_da_valid", {63'd0, da_valid}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("abort_flush", {63'd0, da_valid}, 64'd0);
        end
        chk("abort_no_done", 64'(done_cnt - dc), 64'd0);
        exp_q.delete();
        mon_en = 1'b1;

        // Randomized bursts with a scrambled ROM.
        rom_mode = 1'b1;
        for (int k = 0; k < 8; k++) begin
            logic [15:0] p;
            int sa;
            int la;
            f  = $urandom_range(32'h0100_0000, 32'h0800_0000);
            p  = 16'($urandom_range(0, 3));
            sa = (p == 16'd0) ? int'($urandom_range(0, 200))
                              : (($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 300)));
            la = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 100));
            run_burst(f, 10'($urandom_range(0, 1023)), p, sa, la,
                      $urandom_range(32'h0100_0000, 32'h0800_0000));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
